// File: rtl/register_file_if.sv
// Register file port bundle: write port, two read ports, reserve port and status.
// master drives addresses/data/strobes; slave (the register file) drives read data and busy flags.
interface register_file_if #(
    parameter int N     = 16,
    parameter int DEPTH = 8
);
    localparam int A = $clog2(DEPTH);

    logic         Load;
    logic [A-1:0] DR;
    logic [N-1:0] In;
    logic [A-1:0] SR1;
    logic [A-1:0] SR2;
    logic [N-1:0] Out1;
    logic [N-1:0] Out2;
    logic         Reserve;
    logic [A-1:0] ResDR;
    logic         Busy1;
    logic         Busy2;
    logic         AnyBusy;

    modport master (
        output Load, DR, In, SR1, SR2, Reserve, ResDR,
        input  Out1, Out2, Busy1, Busy2, AnyBusy
    );

    modport slave (
        input  Load, DR, In, SR1, SR2, Reserve, ResDR,
        output Out1, Out2, Busy1, Busy2, AnyBusy
    );
endinterface

// File: rtl/register_file.sv
// DEPTH x N register bank with one write port, two combinational read ports and a
// per-register pending (scoreboard) bit used to track outstanding writes.
// Ports: Clk, Reset (sync, active-high), bus (register_file_if.slave):
//   Load/DR/In write, SR1/SR2 -> Out1/Out2 read, Reserve/ResDR set pending,
//   Busy1/Busy2 pending of SR1/SR2, AnyBusy = OR of all pending bits.
// Optional: define REGFILE_BYPASS_EN for same-cycle write-through forwarding.
module register_file #(
    parameter int  N     = 16,
    parameter int  DEPTH = 8,
    localparam int A     = $clog2(DEPTH)
) (
    input logic             Clk,
    input logic             Reset,
    register_file_if.slave  bus
);

    logic [N-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] pend;
    logic [DEPTH-1:0] pend_nxt;

    logic [N-1:0]     rd1;
    logic [N-1:0]     rd2;
    logic             bz1;
    logic             bz2;

    // Load clears, Reserve sets; Reserve is applied last so the new producer wins.
    // Out-of-range addresses match no entry and are therefore ignored.
    always_comb begin
        pend_nxt = pend;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.Load && bus.DR == A'(i))
                pend_nxt[i] = 1'b0;
            if (bus.Reserve && bus.ResDR == A'(i))
                pend_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            pend <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (bus.Load && bus.DR == A'(i))
                    mem[i] <= bus.In;
            pend <= pend_nxt;
        end
    end

    // Address-match read mux: an address past DEPTH-1 selects nothing and reads 0.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        bz1 = 1'b0;
        bz2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.SR1 == A'(i)) begin
                rd1 = mem[i];
                bz1 = pend[i];
            end
            if (bus.SR2 == A'(i)) begin
                rd2 = mem[i];
                bz2 = pend[i];
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    localparam logic [A:0] DEPTH_W = (A+1)'(DEPTH);

    logic fwd1;
    logic fwd2;

    // Forward the in-flight write; suppressed during reset so the cleared
    // state is what the read ports see.
    always_comb begin
        fwd1 = !Reset && bus.Load && (bus.DR == bus.SR1)
               && ({1'b0, bus.SR1} < DEPTH_W);
        fwd2 = !Reset && bus.Load && (bus.DR == bus.SR2)
               && ({1'b0, bus.SR2} < DEPTH_W);
    end

    // A forwarded value is complete, so it is busy only if the same cycle
    // also reserves that register for a new producer.
    always_comb begin
        bus.Out1  = fwd1 ? bus.In : rd1;
        bus.Out2  = fwd2 ? bus.In : rd2;
        bus.Busy1 = fwd1 ? (bus.Reserve && bus.ResDR == bus.SR1) : bz1;
        bus.Busy2 = fwd2 ? (bus.Reserve && bus.ResDR == bus.SR2) : bz2;
    end
`else
    always_comb begin
        bus.Out1  = rd1;
        bus.Out2  = rd2;
        bus.Busy1 = bz1;
        bus.Busy2 = bz2;
    end
`endif

    assign bus.AnyBusy = |pend;

endmodule
